// File: rtl/twdl_pkg.sv
// rtl/twdl_pkg.sv - shared types, constants and helpers for the twiddle-parameter sequencer
package twdl_pkg;

    localparam int TWDL_WNUM    = 12;
    localparam int TWDL_WQUO    = 20;
    localparam int TWDL_DIV_CYC = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_RUN  = 2'd2
    } twdl_state_t;

    // Radices supported by the butterfly datapath downstream
    function automatic logic twdl_factor_ok(input logic [2:0] f);
        return (f >= 3'd2) && (f <= 3'd5);
    endfunction

endpackage

// File: rtl/twdl_step_div.sv
// rtl/twdl_step_div.sv - serial restoring divider producing floor(2^wQuo/D) and 2^wQuo mod D
module twdl_step_div
    import twdl_pkg::*;
#(
    parameter int wNum = TWDL_WNUM,
    parameter int wQuo = TWDL_WQUO
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [wNum-1:0] d,
    output logic [wQuo-1:0] q_s,
    output logic [wNum-1:0] r_s,
    output logic            done
);

    localparam int CW = $clog2(wQuo + 1);
    localparam logic [CW-1:0] LAST = CW'(wQuo);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [wNum-1:0] d_q;
    logic [wNum-1:0] rem;
    logic [wQuo-1:0] quo;
    logic [CW-1:0]   cnt;
    logic [wNum:0]   rem_sh;
    logic [wNum:0]   rem_dif;
    logic            ge;

    // The dividend's leading 1 is preloaded as the partial remainder: with
    // D >= 2 the top quotient bit is always 0, so wQuo iterations suffice.
    assign rem_sh  = {rem, 1'b0};
    assign rem_dif = rem_sh - {1'b0, d_q};
    assign ge      = (rem_sh >= {1'b0, d_q});

    // One quotient bit per cycle after start; counter parks at LAST when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= '0;
            rem <= '0;
            quo <= '0;
            cnt <= LAST;
        end else if (start) begin
            d_q <= d;
            rem <= {{(wNum-1){1'b0}}, 1'b1};
            quo <= '0;
            cnt <= '0;
        end else if (cnt != LAST) begin
            rem <= ge ? rem_dif[wNum-1:0] : rem_sh[wNum-1:0];
            quo <= {quo[wQuo-2:0], ge};
            cnt <= cnt + ONE;
        end
    end

    assign q_s  = quo;
    assign r_s  = rem;
    assign done = (cnt == LAST);

endmodule

// File: rtl/twdl_param_gen.sv
// rtl/twdl_param_gen.sv - per-butterfly twiddle N/D/Q/R sequencer; TWDL_PARAM_GEN_IFFT_EN selects inverse stepping
module twdl_param_gen
    import twdl_pkg::*;
#(
    parameter int wNum = TWDL_WNUM,
    parameter int wQuo = TWDL_WQUO
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_val,
    input  logic [2:0]      cfg_factor,
    input  logic [wNum-1:0] cfg_demontr,
    input  logic [wNum-1:0] cfg_span,
    input  logic [wNum-1:0] cfg_nbfly,
    input  logic            bfly_req,
    output logic            param_rdy,
    output logic [2:0]      factor,
    output logic [wNum-1:0] twdl_numrtr_1,
    output logic [wNum-1:0] twdl_demontr,
    output logic [wQuo-1:0] twdl_quotient,
    output logic [wNum-1:0] twdl_remainder,
    output logic            stage_done,
    output logic            cfg_err
);

    localparam logic [wNum-1:0] ONE_N = wNum'(1);
    localparam logic [wNum-1:0] TWO_N = wNum'(2);

    twdl_state_t     state, state_nxt;

    logic [2:0]      fac_q;
    logic [wNum-1:0] d_q, l_q, nb_q;
    logic [wNum-1:0] j, bfly_cnt;

    logic [wQuo-1:0] q_s;
    logic [wNum-1:0] r_s;
    logic            div_done;

    logic [wNum+2:0] span_prod;
    logic            cfg_ok, consume, last;
    logic            accept, reject, run_load, step, finish;

    logic [wNum-1:0] j_inc, j_nxt, n_nxt, r_nxt;
    logic [wQuo-1:0] q_nxt;
    logic            wrap;

    assign span_prod = {3'b000, cfg_span} * {{wNum{1'b0}}, cfg_factor};
    assign cfg_ok    = twdl_factor_ok(cfg_factor) && (cfg_demontr >= TWO_N) &&
                       (cfg_nbfly != '0) && (span_prod == {3'b000, cfg_demontr});
    assign consume   = param_rdy & bfly_req;
    assign last      = (bfly_cnt == nb_q - ONE_N);

    twdl_step_div #(.wNum(wNum), .wQuo(wQuo)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .d     (cfg_demontr),
        .q_s   (q_s),
        .r_s   (r_s),
        .done  (div_done)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cfg_val && cfg_ok)  state_nxt = ST_DIV;
            ST_DIV:  if (div_done)           state_nxt = ST_RUN;
            ST_RUN:  if (consume && last)    state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // FSM control decode
    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        run_load = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = cfg_val & cfg_ok;
                reject = cfg_val & ~cfg_ok;
            end
            ST_DIV:  run_load = div_done;
            ST_RUN: begin
                step   = consume & ~last;
                finish = consume & last;
            end
            default: ;
        endcase
    end

    // Next butterfly's parameters: one carry-corrected add (or borrow-corrected subtract)
    always_comb begin
        logic [wNum:0] r_tmp;
        logic          cy;
        j_inc = j + ONE_N;
        wrap  = (j_inc == l_q);
        j_nxt = wrap ? '0 : j_inc;
`ifdef TWDL_PARAM_GEN_IFFT_EN
        r_tmp = {1'b0, twdl_remainder} - {1'b0, r_s};
        cy    = r_tmp[wNum];
        if (cy) r_tmp = r_tmp + {1'b0, d_q};
        q_nxt = twdl_quotient - q_s - {{(wQuo-1){1'b0}}, cy};
        n_nxt = (j_nxt == '0) ? '0 : d_q - j_nxt;
`else
        r_tmp = {1'b0, twdl_remainder} + {1'b0, r_s};
        cy    = (r_tmp >= {1'b0, d_q});
        if (cy) r_tmp = r_tmp - {1'b0, d_q};
        q_nxt = twdl_quotient + q_s + {{(wQuo-1){1'b0}}, cy};
        n_nxt = j_nxt;
`endif
        r_nxt = r_tmp[wNum-1:0];
        if (wrap) begin
            n_nxt = '0;
            q_nxt = '0;
            r_nxt = '0;
        end
    end

    // Descriptor capture, accumulators and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fac_q          <= '0;
            d_q            <= '0;
            l_q            <= '0;
            nb_q           <= '0;
            j              <= '0;
            bfly_cnt       <= '0;
            param_rdy      <= 1'b0;
            factor         <= '0;
            twdl_numrtr_1  <= '0;
            twdl_demontr   <= '0;
            twdl_quotient  <= '0;
            twdl_remainder <= '0;
            stage_done     <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            cfg_err    <= reject;
            stage_done <= finish;
            if (accept) begin
                fac_q <= cfg_factor;
                d_q   <= cfg_demontr;
                l_q   <= cfg_span;
                nb_q  <= cfg_nbfly;
            end
            if (run_load) begin
                param_rdy      <= 1'b1;
                factor         <= fac_q;
                twdl_demontr   <= d_q;
                j              <= '0;
                bfly_cnt       <= '0;
                twdl_numrtr_1  <= '0;
                twdl_quotient  <= '0;
                twdl_remainder <= '0;
            end
            if (step) begin
                j              <= j_nxt;
                bfly_cnt       <= bfly_cnt + ONE_N;
                twdl_numrtr_1  <= n_nxt;
                twdl_quotient  <= q_nxt;
                twdl_remainder <= r_nxt;
            end
            if (finish) param_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_twdl_param_gen.sv
// tb/tb_twdl_param_gen.sv - directed scoreboard bench for twdl_param_gen
module tb_twdl_param_gen;

    typedef struct {
        int n;
        int q;
        int r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_val;
    logic [2:0]  cfg_factor;
    logic [11:0] cfg_demontr, cfg_span, cfg_nbfly;
    logic        bfly_req;
    logic        param_rdy;
    logic [2:0]  factor;
    logic [11:0] twdl_numrtr_1, twdl_demontr, twdl_remainder;
    logic [19:0] twdl_quotient;
    logic        stage_done, cfg_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    twdl_param_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_val        (cfg_val),
        .cfg_factor     (cfg_factor),
        .cfg_demontr    (cfg_demontr),
        .cfg_span       (cfg_span),
        .cfg_nbfly      (cfg_nbfly),
        .bfly_req       (bfly_req),
        .param_rdy      (param_rdy),
        .factor         (factor),
        .twdl_numrtr_1  (twdl_numrtr_1),
        .twdl_demontr   (twdl_demontr),
        .twdl_quotient  (twdl_quotient),
        .twdl_remainder (twdl_remainder),
        .stage_done     (stage_done),
        .cfg_err        (cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int f, input int d, input int l, input int nb);
        cfg_factor  = 3'(f);
        cfg_demontr = 12'(d);
        cfg_span    = 12'(l);
        cfg_nbfly   = 12'(nb);
    endtask

    task automatic drive_cfg(input int f, input int d, input int l, input int nb);
        set_cfg(f, d, l, nb);
        cfg_val = 1'b1;
        tick();
        cfg_val = 1'b0;
    endtask

    // Called right after the accepting edge; the first set must appear 21 edges later
    task automatic wait_rdy();
        int n = 0;
        while (!param_rdy && n < 40) begin
            tick();
            n++;
        end
        chk("rdy_latency", 32'(n), 32'd21);
    endtask

    task automatic push_exp(input int d, input int l, input int nb);
        for (int k = 0; k < nb; k++) begin
            exp_t e;
            int   jj;
            longint sc;
            jj = k % l;
`ifdef TWDL_PARAM_GEN_IFFT_EN
            e.n = (jj == 0) ? 0 : d - jj;
`else
            e.n = jj;
`endif
            sc  = longint'(e.n) * 64'd1048576;
            e.q = int'(sc / longint'(d));
            e.r = int'(sc % longint'(d));
            sb.push_back(e);
        end
    endtask

    task automatic consume(input int cnt, input bit gap, input bit cfg_on_last);
        for (int i = 0; i < cnt; i++) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
                return;
            end
            cur = sb.pop_front();
            chk("numrtr", 32'(twdl_numrtr_1), 32'(cur.n));
            chk("quotient", 32'(twdl_quotient), 32'(cur.q));
            chk("remainder", 32'(twdl_remainder), 32'(cur.r));
            if (gap) begin
                bfly_req = 1'b0;
                tick();
                chk("hold_numrtr", 32'(twdl_numrtr_1), 32'(cur.n));
                chk("hold_quotient", 32'(twdl_quotient), 32'(cur.q));
            end
            bfly_req = 1'b1;
            if (cfg_on_last && i == cnt - 1) begin
                set_cfg(4, 20, 5, 1);
                cfg_val = 1'b1;
            end
            tick();
            bfly_req = 1'b0;
            cfg_val  = 1'b0;
        end
    endtask

    task automatic end_stage(input int d);
        chk("rdy_fall", 32'(param_rdy), 32'd0);
        chk("stage_done", 32'(stage_done), 32'd1);
        chk("demontr_hold", 32'(twdl_demontr), 32'(d));
        tick();
        chk("stage_done_pulse", 32'(stage_done), 32'd0);
        chk("idle_numrtr_hold", 32'(twdl_numrtr_1), 32'(cur.n));
        chk("idle_remainder_hold", 32'(twdl_remainder), 32'(cur.r));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"}, 32'(param_rdy), 32'd0);
        chk({tag, "_factor"}, 32'(factor), 32'd0);
        chk({tag, "_numrtr"}, 32'(twdl_numrtr_1), 32'd0);
        chk({tag, "_demontr"}, 32'(twdl_demontr), 32'd0);
        chk({tag, "_quotient"}, 32'(twdl_quotient), 32'd0);
        chk({tag, "_remainder"}, 32'(twdl_remainder), 32'd0);
        chk({tag, "_done"}, 32'(stage_done), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_val  = 1'b0;
        bfly_req = 1'b0;
        set_cfg(0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk_all_zero("reset");

        // Radix 4, back-to-back requests
        drive_cfg(4, 16, 4, 8);
        chk("a_err", 32'(cfg_err), 32'd0);
        wait_rdy();
        chk("a_factor", 32'(factor), 32'd4);
        chk("a_demontr", 32'(twdl_demontr), 32'd16);
        push_exp(16, 4, 8);
        consume(8, 1'b0, 1'b0);
        end_stage(16);

        // Requests while idle are ignored
        bfly_req = 1'b1;
        tick();
        bfly_req = 1'b0;
        chk("idle_req_rdy", 32'(param_rdy), 32'd0);
        chk("idle_req_done", 32'(stage_done), 32'd0);

        // Radix 5 with a carry every step, gaps between requests
        drive_cfg(5, 15, 3, 3);
        wait_rdy();
        chk("b_factor", 32'(factor), 32'd5);
        push_exp(15, 3, 3);
        consume(3, 1'b1, 1'b0);
        end_stage(15);

        // Rejected descriptors, then a valid one on the next cycle
        drive_cfg(6, 12, 2, 1);
        chk("err_factor", 32'(cfg_err), 32'd1);
        chk("err_factor_rdy", 32'(param_rdy), 32'd0);
        drive_cfg(2, 12, 5, 2);
        chk("err_span", 32'(cfg_err), 32'd1);
        drive_cfg(2, 0, 0, 1);
        chk("err_dmin", 32'(cfg_err), 32'd1);
        drive_cfg(2, 8, 4, 0);
        chk("err_nbfly", 32'(cfg_err), 32'd1);
        drive_cfg(2, 8, 4, 5);
        chk("c_err", 32'(cfg_err), 32'd0);
        wait_rdy();
        push_exp(8, 4, 5);
        consume(5, 1'b0, 1'b1);
        end_stage(8);
        repeat (25) tick();
        chk("late_cfg_rdy", 32'(param_rdy), 32'd0);
        chk("late_cfg_demontr", 32'(twdl_demontr), 32'd8);
        chk("late_cfg_err", 32'(cfg_err), 32'd0);

        // Reset mid-RUN
        drive_cfg(3, 9, 3, 6);
        wait_rdy();
        push_exp(9, 3, 6);
        consume(2, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        chk_all_zero("midrst");
        tick();
        chk("midrst_no_done", 32'(stage_done), 32'd0);

        // Fresh descriptor at the width limit
        drive_cfg(2, 4094, 2047, 5);
        wait_rdy();
        chk("e_demontr", 32'(twdl_demontr), 32'd4094);
        push_exp(4094, 2047, 5);
        consume(5, 1'b0, 1'b0);
        end_stage(4094);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twdl_param_gen.md
# twdl_param_gen

Twiddle-parameter sequencer for one CTA radix stage. Accepts a stage descriptor (factor, twiddle denominator, group span, butterfly count) and emits, one set per butterfly, the twiddle numerator, denominator, and the 2^20-scaled quotient/remainder of numerator/denominator. These outputs feed the twiddle-multiply stage's `twdl_numrtr_1`/`twdl_demontr`/`twdl_quotient`/`twdl_remainder` inputs. A serial divider computes the per-step increment once per stage; after that, every butterfly advance is a single add with carry.

## Interface
- `wNum`, 12: numerator, denominator, span and count width
- `wQuo`, 20: quotient width (scale 2^wQuo)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `cfg_val`  in  1  stage descriptor strobe
- `cfg_factor`  in  3  radix: 2, 3, 4 or 5
- `cfg_demontr`  in  wNum  twiddle denominator D = span·factor
- `cfg_span`  in  wNum  group span L (j wraps at L)
- `cfg_nbfly`  in  wNum  butterflies in the stage, 1..4095
- `bfly_req`  in  1  consume current set, advance to the next
- `param_rdy`  out  1  parameter outputs valid
- `factor`  out  3  registered radix
- `twdl_numrtr_1`  out  wNum  numerator N for the current butterfly
- `twdl_demontr`  out  wNum  registered D
- `twdl_quotient`  out  wQuo  floor(N·2^20 / D)
- `twdl_remainder`  out  wNum  N·2^20 mod D
- `stage_done`  out  1  one-cycle pulse after the last butterfly is consumed
- `cfg_err`  out  1  one-cycle pulse when a descriptor is rejected

## Operation
- FSM states:
  - IDLE → DIV on an accepted `cfg_val`.
  - DIV → RUN after 20 divider iterations.
  - RUN → IDLE after the `cfg_nbfly`-th consumed request.
- Descriptor accepted only in IDLE.
- Descriptor rejected (`cfg_err` pulse, stay in IDLE) when any of these holds:
  - `cfg_factor` is not in {2,3,4,5}
  - D < 2
  - `cfg_nbfly` = 0
  - `cfg_span`·`cfg_factor` ≠ D
- `cfg_val` outside IDLE is ignored silently. This includes the cycle of the final `bfly_req`.
- DIV: restoring divider computes step quotient q_s = floor(2^20/D) and step remainder r_s = 2^20 mod D.
- RUN: butterfly index j starts at 0; outputs are N=0, Q=0, R=0.
- Consume = `param_rdy` & `bfly_req`. On consume:
  - j ← (j+1 = L) ? 0 : j+1.
  - Normal step: R' = R + r_s; if R' ≥ D then R' −= D and carry = 1. Q' = Q + q_s + carry (mod 2^20).
  - Wrap to j=0 reloads N, Q and R to 0.
- `bfly_req` while `param_rdy` is low is ignored.
- Q and R never exceed their widths: R < D ≤ 4095 and N < D.
- `stage_done` pulses once, on the cycle `param_rdy` falls.

## Timing
- Reset: all outputs 0, FSM in IDLE, j = 0.
- Reset mid-stage aborts it; no `stage_done` is emitted.
- `cfg_val` sampled at edge T.
- DIV occupies edges T+1..T+20.
- `param_rdy`, first set and registered `factor`/`twdl_demontr` valid from edge T+21.
- Consume at edge E: the next set appears at E+1. Back-to-back requests sustain one set per cycle.
- Last consume at edge E: at E+1, `param_rdy` = 0, `stage_done` = 1, FSM in IDLE.
- New `cfg_val` is accepted from E+1 onward.
- Parameter outputs hold their last value while idle.
- `cfg_err` asserts at T+1.

## Configuration
- `TWDL_PARAM_GEN_IFFT_EN` defined (inverse transform): output N = (D − j) mod D.
  - Step becomes a subtract: R' = R − r_s; if it borrows then R' += D and borrow = 1. Q' = Q − q_s − borrow (mod 2^20).
  - Wrap to j=0 reloads 0.
- Undefined (forward transform): additive stepping as in Operation.

## Structure
- Package `twdl_pkg`:
  - FSM state enum (IDLE, DIV, RUN)
  - constants `TWDL_WNUM`=12, `TWDL_WQUO`=20, `TWDL_DIV_CYC`=20
  - legal-factor check function
- Sub-module `twdl_step_div`: serial restoring divider.
  - Inputs: start, D.
  - Outputs: q_s, r_s, done after 20 cycles.
- Top module holds the FSM, j/N/Q/R accumulators and the request counter.

## Test plan
- Factor 4, D=16, L=4, nbfly=8, `bfly_req` held high → `param_rdy` at T+21. N = 0,1,2,3,0,1,2,3. Q = 0, 65536, 131072, 196608 repeating. R = 0 throughout. `stage_done` 8 cycles after `param_rdy` rises.
- Factor 5, D=15, L=3, nbfly=3 → q_s=69905, r_s=1. (N,Q,R) = (0,0,0), (1,69905,1), (2,139810,2).
- Same descriptor with `TWDL_PARAM_GEN_IFFT_EN` → second set is N=14, Q=978670, R=14.
- Descriptor factor 6, or D=12 with L=5, factor 2 → `cfg_err` at T+1, `param_rdy` stays 0. A valid descriptor issued next cycle is accepted.
- `cfg_val` with a new descriptor on the final-consume edge → ignored. `stage_done` pulses; outputs still show the old D.
- `rst_n` low for one cycle mid-RUN → all outputs 0 next edge, no `stage_done`. A fresh descriptor restarts at N=0.
